cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, result data width.
REQ-002 Parameter ROB_IDX_W, default 5, ROB index width (32-entry ROB).
REQ-003 Parameter N_REQ, fixed at 4, requesters: 0=ALU, 1=MUL, 2=MEM, 3=BR.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  mispredict flush, synchronous, same cycle as ROB flush.
REQ-007 req_valid  in  N_REQ  per-FU result valid.
REQ-008 req_ready  out  N_REQ  per-FU holding buffer can accept.
REQ-009 req_rd_addr  in  N_REQ x 5  destination architectural register.
REQ-010 req_rob_idx  in  N_REQ x ROB_IDX_W  ROB tag of result.
REQ-011 req_data  in  N_REQ x DATA_W  result value.
REQ-012 cdb_valid  out  1  broadcast valid this cycle.
REQ-013 cdb_src  out  2  index of granted requester.
REQ-014 cdb_rd_addr / cdb_rob_idx / cdb_data  out  5 / ROB_IDX_W / DATA_W  broadcast payload.

Function
REQ-015 Each requester SHALL own a one-entry holding buffer (valid bit + payload).
REQ-016 req_ready[i] SHALL be 1 when buffer i empty, or full and granted this cycle; 0 whenever flush=1.
REQ-017 Handshake: transfer on req_valid[i] && req_ready[i]; payload captured at that edge; FU must hold payload while valid && !ready.
REQ-018 At most one buffer SHALL be granted per cycle; grant = first full buffer searching from rr_ptr upward, modulo 4.
REQ-019 After a grant to i, rr_ptr SHALL become (i+1) mod 4; with no grant rr_ptr SHALL hold.
REQ-020 Granted buffer SHALL clear at the edge unless simultaneously refilled by its own handshake (refill wins, buffer stays full).
REQ-021 Broadcast payload SHALL equal the granted buffer contents unmodified; cdb_src = granted index.
REQ-022 Latency (no macro): handshake at edge N, earliest cdb_valid in cycle N+1 (combinational from buffers).
REQ-023 No full buffer -> cdb_valid=0, payload outputs 0.
REQ-024 Throughput: one broadcast per cycle sustained while any buffer full; a lone requester streaming every cycle SHALL see ready=1 every cycle.
REQ-025 Starvation bound: a full buffer SHALL be granted within 4 cycles.
REQ-026 flush=1: no grant, cdb_valid=0, all buffers and output stage cleared at the edge; rr_ptr held; handshakes in the flush cycle discarded.

Reset
REQ-027 rst=0 SHALL immediately clear all buffer valids, output stage, rr_ptr=0, independent of clk.
REQ-028 During reset: req_ready=0, cdb_valid=0, cdb_src=0, payload outputs 0.
REQ-029 Reset mid-operation SHALL drop all held results without broadcast; first grant after release uses rr_ptr=0.

Configuration
REQ-030 Macro CDB_ARBITER_OUTREG_EN defined: grant result SHALL be registered; cdb_* driven from a flop stage, latency N+2, throughput unchanged, flush also clears the stage.
REQ-031 Macro undefined: cdb_* combinational from buffers per REQ-022; no output stage.

Verification
REQ-032 Reset release, ALU req_valid=1 rd=5 rob=3 data=0xDEADBEEF one cycle -> next cycle cdb_valid=1 src=0 rd=5 rob=3 data=0xDEADBEEF, then cdb_valid=0.
REQ-033 All four buffers filled same edge, rr_ptr=0 -> broadcasts src 0,1,2,3 in four consecutive cycles, rr_ptr ends 0.
REQ-034 MEM streams every cycle while BR held full -> BR granted within 4 cycles, MEM ready never drops for more than 1 cycle.
REQ-035 Buffers 1 and 3 full, flush=1 one cycle -> cdb_valid=0 that cycle and after, req_ready=0 during flush, no payload broadcast.
REQ-036 rst asserted between clock edges with two buffers full -> cdb_valid and req_ready fall to 0 before next edge; after release no stale broadcast.
REQ-037 With CDB_ARBITER_OUTREG_EN: REQ-032 stimulus -> cdb_valid exactly two cycles after handshake, same payload.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: four one-entry holding buffers (ALU, MUL, MEM, BR) feeding a
// round-robin broadcast. Define CDB_ARBITER_OUTREG_EN to register the broadcast (one extra cycle).

module cdb_hold_buf #(
    parameter int DATA_W    = 32,
    parameter int ROB_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 load,
    input  logic                 clear,
    input  logic [4:0]           in_rd_addr,
    input  logic [ROB_IDX_W-1:0] in_rob_idx,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 vld,
    output logic [4:0]           rd_addr,
    output logic [ROB_IDX_W-1:0] rob_idx,
    output logic [DATA_W-1:0]    data
);
    // A refill in the cycle the entry is granted keeps it full with the new result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld     <= 1'b0;
            rd_addr <= '0;
            rob_idx <= '0;
            data    <= '0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (load) begin
            vld     <= 1'b1;
            rd_addr <= in_rd_addr;
            rob_idx <= in_rob_idx;
            data    <= in_data;
        end else if (clear) begin
            vld <= 1'b0;
        end
    end
endmodule

module cdb_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ROB_IDX_W = 5,
    parameter int N_REQ     = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [N_REQ-1:0]                    req_valid,
    output logic [N_REQ-1:0]                    req_ready,
    input  logic [N_REQ-1:0][4:0]               req_rd_addr,
    input  logic [N_REQ-1:0][ROB_IDX_W-1:0]     req_rob_idx,
    input  logic [N_REQ-1:0][DATA_W-1:0]        req_data,
    output logic                                cdb_valid,
    output logic [1:0]                          cdb_src,
    output logic [4:0]                          cdb_rd_addr,
    output logic [ROB_IDX_W-1:0]                cdb_rob_idx,
    output logic [DATA_W-1:0]                   cdb_data
);
    logic [N_REQ-1:0]                buf_vld;
    logic [N_REQ-1:0][4:0]           buf_rd;
    logic [N_REQ-1:0][ROB_IDX_W-1:0] buf_rob;
    logic [N_REQ-1:0][DATA_W-1:0]    buf_data;
    logic [N_REQ-1:0]                grant;
    logic [N_REQ-1:0]                hs;
    logic [1:0]                      rr_ptr;
    logic [1:0]                      gnt_idx;
    logic [1:0]                      scan_idx;
    logic                            gnt_any;
    logic [4:0]                      sel_rd;
    logic [ROB_IDX_W-1:0]            sel_rob;
    logic [DATA_W-1:0]               sel_data;

    // First full buffer at or after rr_ptr wins; nothing is granted while flushing.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = rr_ptr;
        scan_idx = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = rr_ptr + 2'(k);
            if (!gnt_any && buf_vld[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (flush) gnt_any = 1'b0;
    end

    assign grant     = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
    assign req_ready = (rst && !flush) ? (~buf_vld | grant) : '0;
    assign hs        = req_valid & req_ready;

    for (genvar i = 0; i < N_REQ; i++) begin : g_buf
        cdb_hold_buf #(.DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W)) u_buf (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .load       (hs[i]),
            .clear      (grant[i]),
            .in_rd_addr (req_rd_addr[i]),
            .in_rob_idx (req_rob_idx[i]),
            .in_data    (req_data[i]),
            .vld        (buf_vld[i]),
            .rd_addr    (buf_rd[i]),
            .rob_idx    (buf_rob[i]),
            .data       (buf_data[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         rr_ptr <= 2'd0;
        else if (gnt_any) rr_ptr <= gnt_idx + 2'd1;
    end

    assign sel_rd   = gnt_any ? buf_rd[gnt_idx]   : '0;
    assign sel_rob  = gnt_any ? buf_rob[gnt_idx]  : '0;
    assign sel_data = gnt_any ? buf_data[gnt_idx] : '0;

`ifdef CDB_ARBITER_OUTREG_EN
    // Payload is zeroed alongside the valid so idle cycles drive all-zero outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            cdb_valid   <= 1'b0;
            cdb_src     <= '0;
            cdb_rd_addr <= '0;
            cdb_rob_idx <= '0;
            cdb_data    <= '0;
        end else begin
            cdb_valid   <= gnt_any;
            cdb_src     <= gnt_any ? gnt_idx : 2'd0;
            cdb_rd_addr <= sel_rd;
            cdb_rob_idx <= sel_rob;
            cdb_data    <= sel_data;
        end
    end
`else
    assign cdb_valid   = gnt_any;
    assign cdb_src     = gnt_any ? gnt_idx : 2'd0;
    assign cdb_rd_addr = sel_rd;
    assign cdb_rob_idx = sel_rob;
    assign cdb_data    = sel_data;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: cycle table for arbitration, flush and refill cases, plus
// hand sequences for reset behaviour and the registered-output build.

module tb_cdb_arbiter;
    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][4:0]  req_rd_addr;
    logic [3:0][4:0]  req_rob_idx;
    logic [3:0][31:0] req_data;
    logic             cdb_valid;
    logic [1:0]       cdb_src;
    logic [4:0]       cdb_rd_addr;
    logic [4:0]       cdb_rob_idx;
    logic [31:0]      cdb_data;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    cdb_arbiter #(.DATA_W(32), .ROB_IDX_W(5), .N_REQ(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd_addr(req_rd_addr), .req_rob_idx(req_rob_idx), .req_data(req_data),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rd_addr(cdb_rd_addr),
        .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fl;
        logic [3:0] v;
        logic [7:0] tag;
        logic [3:0] er;
        logic       ev;
        logic [1:0] es;
        logic [7:0] etag;
    } vec_t;

    vec_t tbl[25];

    function automatic logic [4:0]  rd_of(int i);  return 5'(i * 3 + 1); endfunction
    function automatic logic [4:0]  rob_of(int i); return 5'(i + 20);    endfunction
    function automatic logic [31:0] dat_of(logic [7:0] tag, int i);
        return {tag, 16'h0, 8'(i)};
    endfunction

    function automatic logic [44:0] exp_cdb(logic ev, logic [1:0] es, logic [7:0] etag);
        if (!ev) return '0;
        return {1'b1, es, rd_of(int'(es)), rob_of(int'(es)), dat_of(etag, int'(es))};
    endfunction

    function automatic logic [44:0] act_cdb();
        return {cdb_valid, cdb_src, cdb_rd_addr, cdb_rob_idx, cdb_data};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic drive(input logic fl, input logic [3:0] v, input logic [7:0] tag);
        flush     = fl;
        req_valid = v;
        for (int i = 0; i < 4; i++) begin
            req_rd_addr[i] = rd_of(i);
            req_rob_idx[i] = rob_of(i);
            req_data[i]    = dat_of(tag, i);
        end
    endtask

    task automatic drive_beef();
        drive(1'b0, 4'b0001, 8'h00);
        req_rd_addr[0] = 5'd5;
        req_rob_idx[0] = 5'd3;
        req_data[0]    = 32'hDEADBEEF;
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'b1111, 8'h22, 4'b1111, 1'b0, 2'd0, 8'h00};
        tbl[1]  = '{1'b0, 4'b0000, 8'h00, 4'b0001, 1'b1, 2'd0, 8'h22};
        tbl[2]  = '{1'b0, 4'b0000, 8'h00, 4'b0011, 1'b1, 2'd1, 8'h22};
        tbl[3]  = '{1'b0, 4'b0000, 8'h00, 4'b0111, 1'b1, 2'd2, 8'h22};
        tbl[4]  = '{1'b0, 4'b0000, 8'h00, 4'b1111, 1'b1, 2'd3, 8'h22};
        tbl[5]  = '{1'b0, 4'b0000, 8'h00, 4'b1111, 1'b0, 2'd0, 8'h00};
        tbl[6]  = '{1'b0, 4'b1100, 8'h33, 4'b1111, 1'b0, 2'd0, 8'h00};
        tbl[7]  = '{1'b0, 4'b0100, 8'h34, 4'b0111, 1'b1, 2'd2, 8'h33};
        tbl[8]  = '{1'b0, 4'b0100, 8'h35, 4'b1011, 1'b1, 2'd3, 8'h33};
        tbl[9]  = '{1'b0, 4'b0100, 8'h35, 4'b1111, 1'b1, 2'd2, 8'h34};
        tbl[10] = '{1'b0, 4'b0000, 8'h00, 4'b1111, 1'b1, 2'd2, 8'h35};
        tbl[11] = '{1'b0, 4'b0000, 8'h00, 4'b1111, 1'b0, 2'd0, 8'h00};
        tbl[12] = '{1'b0, 4'b1010, 8'h44, 4'b1111, 1'b0, 2'd0, 8'h00};
        tbl[13] = '{1'b1, 4'b0001, 8'h45, 4'b0000, 1'b0, 2'd0, 8'h00};
        tbl[14] = '{1'b0, 4'b0000, 8'h00, 4'b1111, 1'b0, 2'd0, 8'h00};
        tbl[15] = '{1'b0, 4'b0000, 8'h00, 4'b1111, 1'b0, 2'd0, 8'h00};
        tbl[16] = '{1'b0, 4'b1001, 8'h55, 4'b1111, 1'b0, 2'd0, 8'h00};
        tbl[17] = '{1'b0, 4'b0000, 8'h00, 4'b1110, 1'b1, 2'd3, 8'h55};
        tbl[18] = '{1'b0, 4'b0000, 8'h00, 4'b1111, 1'b1, 2'd0, 8'h55};
        tbl[19] = '{1'b0, 4'b0000, 8'h00, 4'b1111, 1'b0, 2'd0, 8'h00};
        tbl[20] = '{1'b0, 4'b0001, 8'h60, 4'b1111, 1'b0, 2'd0, 8'h00};
        tbl[21] = '{1'b0, 4'b0001, 8'h61, 4'b1111, 1'b1, 2'd0, 8'h60};
        tbl[22] = '{1'b0, 4'b0001, 8'h62, 4'b1111, 1'b1, 2'd0, 8'h61};
        tbl[23] = '{1'b0, 4'b0000, 8'h00, 4'b1111, 1'b1, 2'd0, 8'h62};
        tbl[24] = '{1'b0, 4'b0000, 8'h00, 4'b1111, 1'b0, 2'd0, 8'h00};

        // Reset with requests pending: nothing may be accepted or broadcast.
        rst = 1'b0;
        drive(1'b0, 4'b1111, 8'hAA);
        #3;
        chk("reset_ready", 64'(req_ready), 64'h0);
        chk("reset_cdb", 64'(act_cdb()), 64'h0);
        drive(1'b0, 4'b0000, 8'h00);
        #9 rst = 1'b1;
        next_cyc();

`ifndef CDB_ARBITER_OUTREG_EN
        for (int n = 0; n < 25; n++) begin
            drive(tbl[n].fl, tbl[n].v, tbl[n].tag);
            #4;
            chk($sformatf("vec%0d_ready", n), 64'(req_ready), 64'(tbl[n].er));
            chk($sformatf("vec%0d_cdb", n), 64'(act_cdb()),
                64'(exp_cdb(tbl[n].ev, tbl[n].es, tbl[n].etag)));
            next_cyc();
        end

        // Single ALU result, broadcast the next cycle then idle.
        drive_beef();
        next_cyc();
        drive(1'b0, 4'b0000, 8'h00);
        #4;
        chk("beef_cdb", 64'(act_cdb()), {19'h0, 1'b1, 2'd0, 5'd5, 5'd3, 32'hDEADBEEF});
        next_cyc();
        chk("beef_idle", 64'(cdb_valid), 64'h0);

        // Async reset between edges with buffers 1 and 2 full.
        drive(1'b0, 4'b0110, 8'h77);
        next_cyc();
        drive(1'b0, 4'b0000, 8'h00);
        #1;
        chk("pre_rst_cdb", 64'(act_cdb()), 64'(exp_cdb(1'b1, 2'd1, 8'h77)));
        rst = 1'b0;
        #1;
        chk("async_rst_cdb", 64'(act_cdb()), 64'h0);
        chk("async_rst_ready", 64'(req_ready), 64'h0);
        next_cyc();
        #2 rst = 1'b1;
        next_cyc();
        chk("post_rst_stale", 64'(act_cdb()), 64'h0);
        chk("post_rst_ready", 64'(req_ready), 64'hF);
        drive(1'b0, 4'b1001, 8'h88);
        next_cyc();
        drive(1'b0, 4'b0000, 8'h00);
        #1;
        chk("post_rst_ptr0", 64'(act_cdb()), 64'(exp_cdb(1'b1, 2'd0, 8'h88)));
        next_cyc();
        chk("post_rst_next", 64'(act_cdb()), 64'(exp_cdb(1'b1, 2'd3, 8'h88)));
`else
        // Registered output: broadcast lands two cycles after the handshake.
        drive_beef();
        next_cyc();
        drive(1'b0, 4'b0000, 8'h00);
        #4;
        chk("oreg_beef_n1", 64'(cdb_valid), 64'h0);
        next_cyc();
        chk("oreg_beef_n2", 64'(act_cdb()), {19'h0, 1'b1, 2'd0, 5'd5, 5'd3, 32'hDEADBEEF});
        next_cyc();
        chk("oreg_beef_n3", 64'(act_cdb()), 64'h0);

        // All four filled at once (rr_ptr now 1): src 1,2,3,0 on consecutive cycles.
        drive(1'b0, 4'b1111, 8'h99);
        next_cyc();
        drive(1'b0, 4'b0000, 8'h00);
        #2;
        chk("oreg_all_n1", 64'(cdb_valid), 64'h0);
        for (int k = 0; k < 4; k++) begin
            next_cyc();
            chk($sformatf("oreg_all_%0d", k), 64'(act_cdb()),
                64'(exp_cdb(1'b1, 2'(k + 1), 8'h99)));
        end
        next_cyc();
        chk("oreg_all_idle", 64'(cdb_valid), 64'h0);
        chk("oreg_ready", 64'(req_ready), 64'hF);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
